// File: rtl/alu_pipe_pkg.sv
// Shared types for the handshaked ALU: opcode, flag set and control states.
package ptype;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        GTE  = 4'd2,
        LT   = 4'd3,
        NOT1 = 4'd4,
        AND  = 4'd5,
        OR   = 4'd6,
        XOR  = 4'd7,
        SHL  = 4'd8,
        SHR  = 4'd9,
        MUL  = 4'd10
    } operation_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_pipe_seq_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per enabled cycle.
// done flags the final iteration; product is the accumulator including that step.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_sum;

    always_comb begin
        w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
        busy    = r_busy;
        done    = r_busy && (r_cnt == CW'(WIDTH - 1));
        product = w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (en) begin
            if (start) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (done) r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags; held until the consumer accepts.
// Define ALU_MUL_EN to build the multi-cycle MUL path; otherwise MUL is illegal.
module alu_pipe
    import ptype::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  operation_t       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output flags_t           fls,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_result;
    flags_t           r_fls;
    logic             r_ill;

    logic [WIDTH:0]   w_sum, w_dif, w_shl, w_shr;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_res;
    logic             w_carry, w_ovf, w_ill, w_is_mul;
    flags_t           w_fl;
    logic             w_accept, w_load;

    always_comb begin
        w_sh     = op2[SHW-1:0];
        w_sum    = {1'b0, op1} + {1'b0, op2};
        w_dif    = {1'b0, op1} - {1'b0, op2};
        w_shl    = {1'b0, op1} << w_sh;
        // extra low bit catches the last bit shifted out on the right
        w_shr    = {op1, 1'b0} >> w_sh;
        w_res    = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        w_ill    = 1'b0;
        w_is_mul = 1'b0;
        case (op)
            ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (w_sum[WIDTH-1] != op1[WIDTH-1]);
            end
            SUB: begin
                w_res   = w_dif[WIDTH-1:0];
                w_carry = w_dif[WIDTH];
                w_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (w_dif[WIDTH-1] != op1[WIDTH-1]);
            end
            GTE: begin
                w_res   = {{(WIDTH-1){1'b0}}, ~w_dif[WIDTH]};
                w_carry = w_dif[WIDTH];
            end
            LT: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_dif[WIDTH]};
                w_carry = w_dif[WIDTH];
            end
            NOT1: w_res = ~op1;
            AND:  w_res = op1 & op2;
            OR:   w_res = op1 | op2;
            XOR:  w_res = op1 ^ op2;
            SHL: begin
                w_res   = w_shl[WIDTH-1:0];
                w_carry = w_shl[WIDTH];
            end
            SHR: begin
                w_res   = w_shr[WIDTH:1];
                w_carry = w_shr[0];
            end
`ifdef ALU_MUL_EN
            MUL: w_is_mul = 1'b1;
`endif
            default: w_ill = 1'b1;
        endcase
        w_fl = '{carry: w_carry, zero: (w_res == '0), neg: w_res[WIDTH-1], ovf: w_ovf};
    end

`ifdef ALU_MUL_EN
    logic                 w_mul_busy, w_mul_done, w_mul_fin;
    logic [2*WIDTH-1:0]   w_prod;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (w_accept & w_is_mul),
        .a       (op1),
        .b       (op2),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_prod)
    );
    assign w_mul_fin = w_mul_busy & w_mul_done;
`endif

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE:    in_ready = en;
                DONE:    in_ready = en & out_ready;
                default: in_ready = 1'b0;
            endcase
        end
        w_accept = in_valid & in_ready;
        w_load   = w_accept & ~w_is_mul;
        w_next   = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_is_mul ? MULT : DONE;
`ifdef ALU_MUL_EN
            MULT: if (w_mul_fin) w_next = DONE;
`endif
            DONE: if (out_ready) w_next = w_accept ? (w_is_mul ? MULT : DONE) : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_fls    <= '0;
            r_ill    <= 1'b0;
        end else if (en) begin
            r_state <= w_next;
            if (w_load) begin
                r_result <= w_res;
                r_fls    <= w_fl;
                r_ill    <= w_ill;
            end
`ifdef ALU_MUL_EN
            else if (r_state == MULT && w_mul_fin) begin
                r_result <= w_prod[WIDTH-1:0];
                r_fls    <= '{carry: |w_prod[2*WIDTH-1:WIDTH], zero: (w_prod[WIDTH-1:0] == '0),
                              neg: w_prod[WIDTH-1], ovf: 1'b0};
                r_ill    <= 1'b0;
            end
`endif
        end
    end

    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign fls       = r_fls;
    assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases plus random ops under random en/out_ready,
// checked each cycle against an arithmetic model and an expected-output queue.
module tb_alu_pipe;
    import ptype::*;

`ifdef ALU_MUL_EN
    localparam int MULLAT = 16;
`else
    localparam int MULLAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [15:0] op1, op2, result;
    operation_t  op;
    flags_t      fls;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .fls(fls), .illegal(illegal)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  fl;
        logic        ill;
        int          due;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ecount  = 0;
    exp_t q[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(int o, int a, int b);
        exp_t m;
        int s, sa, sb, sh;
        longint p;
        logic c, v, ill;
        c = 1'b0; v = 1'b0; ill = 1'b0; m.res = '0; m.due = 0;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        sh = b % 16;
        p  = 0;
        case (o)
            0: begin s = a + b; m.res = 16'(s); c = (s > 65535);
                     v = (sa + sb > 32767) || (sa + sb < -32768); end
            1: begin s = a - b; m.res = 16'(s); c = (a < b);
                     v = (sa - sb > 32767) || (sa - sb < -32768); end
            2: begin m.res = (a >= b) ? 16'd1 : 16'd0; c = (a < b); end
            3: begin m.res = (a < b) ? 16'd1 : 16'd0; c = (a < b); end
            4: m.res = 16'(~a);
            5: m.res = 16'(a & b);
            6: m.res = 16'(a | b);
            7: m.res = 16'(a ^ b);
            8: begin m.res = 16'(a << sh); c = (sh != 0) && (((a >> (16 - sh)) & 1) != 0); end
            9: begin m.res = 16'(a >> sh); c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
`ifdef ALU_MUL_EN
            10: begin p = longint'(a) * longint'(b); m.res = 16'(p); c = ((p >> 16) != 0); end
`endif
            default: ill = 1'b1;
        endcase
        m.fl  = {c, (m.res == 16'h0), m.res[15], v};
        m.ill = ill;
        return m;
    endfunction

    // Per-cycle checker: output validity, in_ready and held data against the queue
    initial begin : cmp
        exp_t e;
        bit   hv;
        logic er;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                chk("rst_out", 32'({out_valid, in_ready, illegal, fls, result}), 32'd0);
            end else begin
                hv = (q.size() > 0) && (q[0].due <= ecount);
                chk("out_valid", 32'(out_valid), 32'(hv));
                er = (q.size() == 0) ? en : (hv ? (en & out_ready) : 1'b0);
                chk("in_ready", 32'(in_ready), 32'(er));
                if (hv && out_valid)
                    chk("out_data", 32'({result, fls, illegal}), 32'({q[0].res, q[0].fl, q[0].ill}));
                if (hv && out_valid && out_ready && en) void'(q.pop_front());
                if (in_valid && in_ready && en) begin
                    e = model(int'(op), int'(op1), int'(op2));
                    e.due = ecount + 1 + ((op == MUL) ? MULLAT : 0);
                    q.push_back(e);
                end
                if (en) ecount++;
            end
        end
    end

    task automatic rnd_ctl();
        en        = ($urandom % 10) != 0;
        out_ready = ($urandom % 10) < 7;
    endtask

    function automatic int rnd_opnd();
        case ($urandom % 5)
            0: return 0;
            1: return 'hFFFF;
            2: return 'h7FFF;
            3: return 'h8000;
            default: return int'($urandom % 65536);
        endcase
    endfunction

    // Called and returns at posedge+1; holds the op until accepted
    task automatic send(int o, int a, int b, bit rnd);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; op = operation_t'(4'(o)); op1 = 16'(a); op2 = 16'(b);
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (in_ready && en) got = 1'b1;
            @(posedge clk); #1;
            if (!got && rnd) rnd_ctl();
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got no accept expected accept for op %0d", o);
        end
        in_valid = 1'b0; op1 = 16'($urandom); op2 = 16'($urandom); op = operation_t'(4'($urandom));
        if (rnd) rnd_ctl();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!out_valid && n < 60);
        if (!out_valid) begin
            n_tests++; n_fail++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1");
        end
    endtask

    initial begin : stim
        exp_t e;
        int   n;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; op = ADD;

        e = model(0, 'hFFFF, 1);    chk("model_add_c", 32'({e.res, e.fl, e.ill}), 32'({16'h0000, 4'b1100, 1'b0}));
        e = model(0, 'h7FFF, 1);    chk("model_add_v", 32'({e.res, e.fl, e.ill}), 32'({16'h8000, 4'b0011, 1'b0}));
        e = model(1, 5, 7);         chk("model_sub",   32'({e.res, e.fl, e.ill}), 32'({16'hFFFE, 4'b1010, 1'b0}));
        e = model(8, 'h8001, 1);    chk("model_shl",   32'({e.res, e.fl, e.ill}), 32'({16'h0002, 4'b1000, 1'b0}));
        e = model(9, 'h00F1, 4);    chk("model_shr",   32'({e.res, e.fl, e.ill}), 32'({16'h000F, 4'b0000, 1'b0}));
        e = model(13, 'h1234, 1);   chk("model_ill",   32'({e.res, e.fl, e.ill}), 32'({16'h0000, 4'b0100, 1'b1}));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(0, 'hFFFF, 'h0001, 1'b0); wait_valid(n);
        chk("add_lat", 32'(n), 32'd1);
        chk("add_carry", 32'({result, fls, illegal}), 32'({16'h0000, 4'b1100, 1'b0}));
        @(posedge clk); #1;
        send(0, 'h7FFF, 'h0001, 1'b0); wait_valid(n);
        chk("add_ovf", 32'({result, fls, illegal}), 32'({16'h8000, 4'b0011, 1'b0}));
        @(posedge clk); #1;

        send(1, 5, 7, 1'b0); send(3, 5, 7, 1'b0); send(2, 5, 7, 1'b0);
        @(negedge clk);
        chk("b2b_gte", 32'({out_valid, result, fls}), 32'({1'b1, 16'h0000, 4'b1100}));
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(7, 'hF0F0, 'h0FF0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_hold", 32'({out_valid, in_ready, result}), 32'({1'b1, 1'b0, 16'hFF00}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); chk("bp_release", 32'({out_valid, in_ready}), 32'b11);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_idle", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        send(8, 'h8001, 1, 1'b0); wait_valid(n);
        chk("shl", 32'({result, fls, illegal}), 32'({16'h0002, 4'b1000, 1'b0}));
        @(posedge clk); #1;
        send(9, 'hA5A5, 'h0010, 1'b0); wait_valid(n);
        chk("shr0", 32'({result, fls, illegal}), 32'({16'hA5A5, 4'b0010, 1'b0}));
        @(posedge clk); #1;
        send(13, 'h1234, 'h5678, 1'b0); wait_valid(n);
        chk("undef_op", 32'({n[7:0], result, fls, illegal}), 32'({8'd1, 16'h0000, 4'b0100, 1'b1}));
        @(posedge clk); #1;

        send(10, 'h0100, 'h0100, 1'b0); wait_valid(n);
`ifdef ALU_MUL_EN
        chk("mul_lat", 32'(n), 32'd17);
        chk("mul_res", 32'({result, fls, illegal}), 32'({16'h0000, 4'b1100, 1'b0}));
        @(posedge clk); #1;
        send(10, 'h0100, 'h0100, 1'b0);
        n = 0;
        do begin
            @(negedge clk); n++;
            if (!out_valid) begin
                @(posedge clk); #1;
                en = !(n >= 4 && n < 7);
            end
        end while (!out_valid && n < 60);
        en = 1'b1;
        chk("mul_stall_lat", 32'(n), 32'd20);
`else
        chk("mul_off", 32'({n[7:0], result, fls, illegal}), 32'({8'd1, 16'h0000, 4'b0100, 1'b1}));
`endif
        @(posedge clk); #1;

        send(10, 3, 5, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid", 32'({out_valid, result, fls, illegal}), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 400; i++) begin
            send(int'($urandom % 16), rnd_opnd(), rnd_opnd(), 1'b1);
            if ($urandom % 4 == 0)
                repeat ($urandom % 3) begin @(posedge clk); #1; rnd_ctl(); end
        end

        en = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 100 && q.size() > 0; k++) begin @(posedge clk); #1; end
        chk("drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
